// File: rtl/stall_control_unit.sv
// -----------------------------------------------------------------------------
// stall_control_unit
//
// Purpose:
//   Holds the fetch stage and the program counter while a control-flow
//   instruction (jump) or a load is resolved further down the pipeline. It can
//   also freeze the core permanently when a halt instruction is decoded.
//
//   Each jump stalls fetch for JMP_STALL cycles and each load for LD_STALL
//   cycles. Every stall window ends with a single RELEASE cycle. During that
//   cycle stall is low, so the held instruction issues exactly once. It is not
//   re-decoded, which would otherwise start the same window again.
//
// Parameters:
//   INS_W     instruction width (>= 5); opcode is ins_pm[INS_W-1:INS_W-5]
//   JMP_STALL stall cycles per jump (1..15)
//   LD_STALL  stall cycles per load (1..15)
//   HLT_EN    1 = halt opcode freezes the core, 0 = halt opcode is a NOP
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous, active-high reset
//   ins_pm     instruction word from program memory
//   stall      combinational stall request to fetch / PC
//   stall_pm   stall delayed by one cycle (program-memory enable)
//   stall_cnt  remaining stall cycles in the current window (registered)
//   halted     sticky halt flag (registered)
// -----------------------------------------------------------------------------
module stall_control_unit #(
    parameter int INS_W     = 20,
    parameter int JMP_STALL = 2,
    parameter int LD_STALL  = 1,
    parameter int HLT_EN    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INS_W-1:0] ins_pm,
    output logic             stall,
    output logic             stall_pm,
    output logic [3:0]       stall_cnt,
    output logic             halted
);

    typedef enum logic [2:0] {
        IDLE,
        JSTALL,
        LSTALL,
        RELEASE,
        HALT
    } state_t;

    // Counter value loaded on entry to a stall window. The cycle that decodes
    // the instruction is the first stall cycle, so the counter starts one
    // lower than the window length.
    localparam logic [3:0] JMP_INIT = 4'(JMP_STALL - 1);
    localparam logic [3:0] LD_INIT  = 4'(LD_STALL - 1);

    state_t     state;
    logic [4:0] opcode;
    logic       is_jmp;
    logic       is_ld;
    logic       is_hlt;

    // -------------------------------------------------------------------------
    // Decode
    // -------------------------------------------------------------------------
    assign opcode = ins_pm[INS_W-1 -: 5];
    assign is_jmp = (opcode[4:2] == 3'b111);
    assign is_ld  = (opcode == 5'b10100);
    assign is_hlt = (HLT_EN != 0) && (opcode == 5'b10001);

    // Only the opcode field matters here; the remaining bits are reduced into
    // a deliberately unused net.
    generate
        if (INS_W > 5) begin : g_operand_sink
            logic unused_operand_bits;
            assign unused_operand_bits = ^ins_pm[INS_W-6:0];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Combinational stall request
    // -------------------------------------------------------------------------
    // NOTE: every output of an always_comb block gets a default before the
    // case statement. Otherwise a path that does not assign it infers a latch.
    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            unique case (state)
                IDLE:    stall = is_hlt | is_jmp | is_ld;
                JSTALL:  stall = 1'b1;
                LSTALL:  stall = 1'b1;
                HALT:    stall = 1'b1;
                RELEASE: stall = 1'b0;
                default: stall = 1'b0;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State machine and registered outputs
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then sample pre-edge values, regardless of the order of the statements.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            stall_pm  <= 1'b0;
            stall_cnt <= 4'd0;
            halted    <= 1'b0;
        end else begin
            stall_pm <= stall;

            unique case (state)
                IDLE: begin
                    // Halt has the highest priority, then jump, then load.
                    if (is_hlt) begin
                        state     <= HALT;
                        stall_cnt <= 4'd0;
                        halted    <= 1'b1;
                    end else if (is_jmp) begin
                        state     <= (JMP_STALL == 1) ? RELEASE : JSTALL;
                        stall_cnt <= JMP_INIT;
                    end else if (is_ld) begin
                        state     <= (LD_STALL == 1) ? RELEASE : LSTALL;
                        stall_cnt <= LD_INIT;
                    end else begin
                        stall_cnt <= 4'd0;
                    end
                end

                JSTALL, LSTALL: begin
                    // ins_pm is ignored here. A comparison against <= 1
                    // (not == 1) keeps the counter from wrapping if it ever
                    // reaches 0 in these states.
                    if (stall_cnt <= 4'd1) begin
                        state     <= RELEASE;
                        stall_cnt <= 4'd0;
                    end else begin
                        stall_cnt <= stall_cnt - 4'd1;
                    end
                end

                RELEASE: begin
                    // The held instruction issues during this cycle. The next
                    // instruction is decoded fresh in IDLE.
                    state     <= IDLE;
                    stall_cnt <= 4'd0;
                end

                HALT: begin
                    // Only reset leaves this state.
                    stall_cnt <= 4'd0;
                    halted    <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    stall_cnt <= 4'd0;
                    halted    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stall_control_unit.sv
// -----------------------------------------------------------------------------
// tb_stall_control_unit
//
// Two instances share the same clock, reset and instruction bus:
//   u_a : default parameters (JMP_STALL=2, LD_STALL=1, HLT_EN=1)
//   u_b : JMP_STALL=4, LD_STALL=3, HLT_EN=0
//
// The test has three phases:
//   1. A table of per-cycle vectors, checked on u_a.
//   2. Hand-written multi-cycle sequences, checked on u_b.
//   3. Random instructions and resets. Both instances are checked against a
//      schedule-queue reference model.
// -----------------------------------------------------------------------------
module tb_stall_control_unit;

    logic        clk;
    logic        reset;
    logic [19:0] ins_pm;

    logic [1:0]  stall_w;
    logic [1:0]  stall_pm_w;
    logic [1:0]  halted_w;
    logic [3:0]  cnt_w [2];

    int n_cmp = 0;
    int n_bad = 0;

    stall_control_unit u_a (
        .clk       (clk),
        .reset     (reset),
        .ins_pm    (ins_pm),
        .stall     (stall_w[0]),
        .stall_pm  (stall_pm_w[0]),
        .stall_cnt (cnt_w[0]),
        .halted    (halted_w[0])
    );

    stall_control_unit #(
        .INS_W     (20),
        .JMP_STALL (4),
        .LD_STALL  (3),
        .HLT_EN    (0)
    ) u_b (
        .clk       (clk),
        .reset     (reset),
        .ins_pm    (ins_pm),
        .stall     (stall_w[1]),
        .stall_pm  (stall_pm_w[1]),
        .stall_cnt (cnt_w[1]),
        .halted    (halted_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge. Then wait for the
    // falling edge, so outputs can be sampled away from the active edge.
    task automatic step(input logic r, input logic [19:0] ins);
        @(posedge clk);
        #1;
        reset  = r;
        ins_pm = ins;
        @(negedge clk);
    endtask

    // One table row: inputs and the expected u_a outputs for that cycle.
    typedef struct {
        logic        rst;
        logic [19:0] ins;
        logic        s;
        logic        pm;
        logic [3:0]  cnt;
        logic        h;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [19:0] ins, input logic s,
                       input logic pm, input logic [3:0] cnt, input logic h);
        vec_t v;
        v.rst = r; v.ins = ins; v.s = s; v.pm = pm; v.cnt = cnt; v.h = h;
        tbl.push_back(v);
    endtask

    // Reference model: each instance keeps a queue of stall values for the
    // cycles that are already committed. A decoded jump or load commits
    // (N-1) stall cycles followed by one release cycle. stall_cnt is the
    // number of committed stall cycles still ahead.
    int  js [2] = '{2, 4};
    int  ls [2] = '{1, 3};
    bit  he [2] = '{1'b1, 1'b0};
    bit  m_halt [2];
    bit  m_pm   [2];
    int  m_cnt  [2];
    bit  sched  [2][$];

    initial begin
        // u_b expected values for the hand-written sequences.
        logic       b_s   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] b_cnt [5] = '{4'd0, 4'd3, 4'd2, 4'd1, 4'd0};
        logic       b_pm  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        reset  = 1'b1;
        ins_pm = '0;
        repeat (2) @(posedge clk);

        // ---------------- phase 1: table vectors on u_a ----------------
        add(1, 20'hE0000, 0, 0, 0, 0);   // reset masks the jump decode
        add(0, 20'hE0000, 1, 0, 0, 0);   // jump decoded in IDLE
        add(0, 20'hE0000, 1, 1, 1, 0);   // JSTALL, count 1
        add(0, 20'hE0000, 0, 1, 0, 0);   // RELEASE
        add(0, 20'hE0000, 1, 0, 0, 0);   // jump decoded again
        add(0, 20'hE0000, 1, 1, 1, 0);
        add(0, 20'hA0000, 0, 1, 0, 0);   // RELEASE ignores the load
        add(0, 20'hA0000, 1, 0, 0, 0);   // load decoded
        add(0, 20'hA0000, 0, 1, 0, 0);   // LD_STALL=1: straight to RELEASE
        add(0, 20'h00000, 0, 0, 0, 0);   // NOP
        add(0, 20'h00000, 0, 0, 0, 0);
        add(0, 20'hE1234, 1, 0, 0, 0);   // opcode 11100 plus operand bits
        add(0, 20'hA8000, 1, 1, 1, 0);   // ignored during JSTALL
        add(0, 20'hA8000, 0, 1, 0, 0);   // RELEASE
        add(0, 20'hA8000, 0, 0, 0, 0);   // opcode 10101 is a NOP
        add(0, 20'h88000, 1, 0, 0, 0);   // halt decoded
        for (int i = 0; i < 10; i++)
            add(0, 20'h00000, 1, 1, 0, 1);
        add(1, 20'h00000, 0, 1, 0, 1);   // reset during HALT
        add(0, 20'h00000, 0, 0, 0, 0);   // cleared
        add(0, 20'h88000, 1, 0, 0, 0);   // halt decoded right after reset
        add(0, 20'hE0000, 1, 1, 0, 1);
        add(1, 20'hE0000, 0, 1, 0, 1);   // reset while halted
        add(0, 20'hE0000, 1, 0, 0, 0);   // first cycle after reset decodes

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].ins);
            check($sformatf("vec%0d_stall", i),    32'(stall_w[0]),    32'(tbl[i].s));
            check($sformatf("vec%0d_stall_pm", i), 32'(stall_pm_w[0]), 32'(tbl[i].pm));
            check($sformatf("vec%0d_cnt", i),      32'(cnt_w[0]),      32'(tbl[i].cnt));
            check($sformatf("vec%0d_halted", i),   32'(halted_w[0]),   32'(tbl[i].h));
        end

        // ---------------- phase 2: hand sequences on u_b ----------------
        step(1, 20'h00000);
        // JMP_STALL=4 with the jump held: four stall cycles, then one release.
        for (int i = 0; i < 5; i++) begin
            step(0, 20'hE0000);
            check($sformatf("b_jmp%0d_stall", i), 32'(stall_w[1]),    32'(b_s[i]));
            check($sformatf("b_jmp%0d_cnt", i),   32'(cnt_w[1]),      32'(b_cnt[i]));
            check($sformatf("b_jmp%0d_pm", i),    32'(stall_pm_w[1]), 32'(b_pm[i]));
        end
        step(0, 20'h00000);
        check("b_after_nop_stall", 32'(stall_w[1]), 32'd0);

        // Reset during the second JSTALL cycle.
        step(0, 20'hE0000);
        check("b_rst_j0_stall", 32'(stall_w[1]), 32'd1);
        step(0, 20'hE0000);
        check("b_rst_j1_cnt", 32'(cnt_w[1]), 32'd3);
        step(1, 20'hE0000);
        check("b_rst_j2_cnt", 32'(cnt_w[1]), 32'd2);
        check("b_rst_masked_stall", 32'(stall_w[1]), 32'd0);
        step(0, 20'h00000);
        check("b_post_rst_stall", 32'(stall_w[1]),    32'd0);
        check("b_post_rst_cnt",   32'(cnt_w[1]),      32'd0);
        check("b_post_rst_pm",    32'(stall_pm_w[1]), 32'd0);
        step(0, 20'h00000);
        check("b_no_residual_stall", 32'(stall_w[1]), 32'd0);

        // With HLT_EN=0 the halt opcode is a NOP.
        step(0, 20'h88000);
        check("b_hlt_dis_stall", 32'(stall_w[1]), 32'd0);
        step(0, 20'h00000);
        check("b_hlt_dis_halted", 32'(halted_w[1]), 32'd0);
        check("b_hlt_dis_stall2", 32'(stall_w[1]), 32'd0);

        // ---------------- phase 3: random against the model ----------------
        step(1, 20'h00000);
        for (int k = 0; k < 2; k++) begin
            m_halt[k] = 0; m_pm[k] = 0; m_cnt[k] = 0; sched[k].delete();
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [4:0] ops [9] = '{5'b11100, 5'b11101, 5'b11110, 5'b11111,
                                    5'b10100, 5'b10001, 5'b10101, 5'b00000, 5'b00000};
            logic [4:0] op;
            logic       r;
            r = ($urandom_range(0, 39) == 0);
            op = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 9) == 0) op = 5'($urandom);
            step(r, {op, 15'($urandom)});
            for (int k = 0; k < 2; k++) begin
                bit is_j, is_l, is_h, exp_s;
                is_j = (op[4:2] == 3'b111);
                is_l = (op == 5'b10100);
                is_h = (op == 5'b10001) && he[k];
                if (r)                       exp_s = 0;
                else if (m_halt[k])          exp_s = 1;
                else if (sched[k].size() > 0) exp_s = sched[k][0];
                else                         exp_s = is_j | is_l | is_h;

                check($sformatf("rnd%0d_u%0d_stall", cyc, k),  32'(stall_w[k]),    32'(exp_s));
                check($sformatf("rnd%0d_u%0d_pm", cyc, k),     32'(stall_pm_w[k]), 32'(m_pm[k]));
                check($sformatf("rnd%0d_u%0d_cnt", cyc, k),    32'(cnt_w[k]),      32'(m_cnt[k]));
                check($sformatf("rnd%0d_u%0d_halted", cyc, k), 32'(halted_w[k]),   32'(m_halt[k]));

                // Advance the model across the coming rising edge.
                if (r) begin
                    sched[k].delete();
                    m_halt[k] = 0;
                    m_pm[k]   = 0;
                end else begin
                    m_pm[k] = exp_s;
                    if (m_halt[k]) begin
                        // stays halted
                    end else if (sched[k].size() > 0) begin
                        void'(sched[k].pop_front());
                    end else if (is_h) begin
                        m_halt[k] = 1;
                    end else if (is_j) begin
                        repeat (js[k] - 1) sched[k].push_back(1'b1);
                        sched[k].push_back(1'b0);
                    end else if (is_l) begin
                        repeat (ls[k] - 1) sched[k].push_back(1'b1);
                        sched[k].push_back(1'b0);
                    end
                end
                m_cnt[k] = 0;
                foreach (sched[k][j]) if (sched[k][j]) m_cnt[k]++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stall_control_unit.md
STALL_CONTROL_UNIT -- requirements
Module: stall_control_unit

Interface
REQ-001 Parameter INS_W, default 20: instruction width (≥5); opcode is ins_pm[INS_W-1:INS_W-5].
REQ-002 Parameter JMP_STALL, default 2: stall cycles per jump (1..15).
REQ-003 Parameter LD_STALL, default 1: stall cycles per load (1..15).
REQ-004 Parameter HLT_EN, default 1: halt detection enabled when 1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 ins_pm  input  INS_W  instruction word from program memory.
REQ-008 stall  output  1  combinational stall request to fetch/PC.
REQ-009 stall_pm  output  1  stall registered one cycle, for program-memory enable.
REQ-010 stall_cnt  output  4  remaining stall cycles in current window, registered.
REQ-011 halted  output  1  sticky halt flag, registered.

Function
REQ-012 Decode: JMP when opcode[4:2]==3'b111; LD when opcode==5'b10100; HLT when opcode==5'b10001; other opcodes are NOP for this block.
REQ-013 FSM states IDLE, JSTALL, LSTALL, RELEASE, HALT; encoding is free.
REQ-014 IDLE, JMP decoded: stall=1 this cycle; next state JSTALL with stall_cnt=JMP_STALL-1; if JMP_STALL==1, next state RELEASE.
REQ-015 IDLE, LD decoded: stall=1 this cycle; next state LSTALL with stall_cnt=LD_STALL-1; if LD_STALL==1, next state RELEASE.
REQ-016 IDLE, HLT decoded with HLT_EN=1: stall=1 this cycle; next state HALT; halted=1 from next cycle.
REQ-017 Priority when decodes overlap: HLT > JMP > LD.
REQ-018 JSTALL/LSTALL: stall=1; ins_pm ignored; stall_cnt decrements by 1 per cycle; when stall_cnt==1 at a clock edge, next state RELEASE with stall_cnt=0.
REQ-019 RELEASE: stall=0 for exactly one cycle regardless of ins_pm (held instruction issues once); next state IDLE.
REQ-020 HALT: stall=1 every cycle; ins_pm ignored; exits only via reset.
REQ-021 IDLE with NOP: stall=0, stall_cnt=0.
REQ-022 Total stall window per jump = JMP_STALL cycles, per load = LD_STALL cycles, each followed by one RELEASE cycle.
REQ-023 stall_pm equals stall of previous cycle; stall_cnt never underflows below 0.
REQ-024 Back-to-back: a JMP/LD/HLT present in the cycle after RELEASE is decoded normally in IDLE.
REQ-025 HLT_EN=0: HLT opcode treated as NOP.

Reset
REQ-026 reset=1 at a rising edge forces state IDLE, stall_pm=0, stall_cnt=0, halted=0, from any state including mid-window and HALT.
REQ-027 While reset=1, stall=0 combinationally (decode masked).
REQ-028 First cycle after reset deasserts is IDLE; an instruction present then is decoded normally.

Verification
REQ-029 Defaults, JMP word 20'hE0000 held 4 cycles after reset -> stall 1,1,0,(re-decode)1; stall_cnt 0→1→0; stall_pm lags by one cycle.
REQ-030 Defaults, LD word 20'hA0000 held -> stall 1,0; next cycle IDLE; NOP 20'h00000 after -> stall stays 0.
REQ-031 HLT word 20'h88000 then NOPs for 10 cycles -> stall=1 and halted=1 for all 10; reset pulse -> halted=0, stall=0 next cycle.
REQ-032 JMP_STALL=4: JMP held -> stall high exactly 4 cycles, stall_cnt 3,2,1,0, then one stall=0 cycle.
REQ-033 Reset asserted in 2nd cycle of JSTALL (JMP_STALL=4) -> next cycle state IDLE, stall_cnt=0, stall_pm=0, no residual stall.
REQ-034 Word with opcode 5'b11100 (JMP and unrelated bits) vs 5'b10101 -> first stalls as JMP, second is NOP (stall=0).
